// File: rtl/ram_port_ctrl_if.sv
// Upstream command/response channel of ram_port_ctrl.
// The master issues commands and the slave (controller) returns read data.
interface ram_port_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// Command FIFO plus sequencer driving one port of a dual-port RAM.
// Writes take 2 cycles and reads take 3, with IDLE acting as the bus turnaround.
module ram_port_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_ctrl_if.slave    host,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FullCnt = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {StIdle, StWr, StRd1, StRd2} state_e;

    state_e            state;
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign full  = (count == FullCnt);
    assign empty = (count == '0);
    assign push  = host.req_valid && !full;
    // Pop uses the registered count, so a push into an empty FIFO pops one edge later.
    assign pop   = (state == StIdle) && !empty;

    assign {head_wr, head_addr, head_data} = fifo_mem[rd_ptr];

    assign host.req_ready = !full;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign busy           = !empty || (state != StIdle);

    // Only the write phase drives the bus; RD1/RD2 leave it to the RAM.
    assign ram_data = (state == StWr) ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {host.req_wr, host.req_addr, host.req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            ram_cs      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_rd      <= 1'b0;
            ram_addr    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (pop) begin
                        ram_cs   <= 1'b1;
                        ram_addr <= head_addr;
                        wdata_q  <= head_data;
                        if (head_wr) begin
                            ram_wr <= 1'b1;
                            state  <= StWr;
                        end else begin
                            ram_rd <= 1'b1;
                            state  <= StRd1;
                        end
                    end
                end
                StWr: begin
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= StIdle;
                end
                StRd1: begin
                    state <= StRd2;
                end
                StRd2: begin
                    rsp_rdata_q <= ram_data;
                    rsp_valid_q <= 1'b1;
                    ram_cs      <= 1'b0;
                    ram_rd      <= 1'b0;
                    state       <= StIdle;
                end
                default: begin
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    ram_rd <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed and random bench for ram_port_ctrl with a behavioural RAM port model.
module tb_ram_port_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

    logic          busy;
    logic          ram_cs;
    logic          ram_wr;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    ram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (host.slave),
        .busy     (busy),
        .ram_cs   (ram_cs),
        .ram_wr   (ram_wr),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    // RAM port: captures ram[addr] at the RD1->RD2 edge and drives it through RD2.
    logic [DW-1:0] ram_mem [256];
    logic          drv;
    logic [DW-1:0] dout;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drv <= 1'b0;
        end else begin
            drv  <= ram_cs && ram_rd;
            dout <= ram_mem[ram_addr];
            if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_data;
        end
    end
    assign ram_data = drv ? dout : {DW{1'bz}};
    // Bus holder: a released bus reads 0x00, so any stray controller drive shows up.
    assign ram_data = (!drv && !ram_wr) ? {DW{1'b0}} : {DW{1'bz}};

    int            total = 0;
    int            bad   = 0;
    int            stalls;
    int            rsp_cnt = 0;
    logic          rsp_prev = 1'b0;
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] wq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("wr_rd_exclusive", {31'd0, ram_wr && ram_rd}, 32'd0);
        check("cs_without_op", {31'd0, ram_cs && !ram_wr && !ram_rd}, 32'd0);
        if (!ram_wr && !drv) check("bus_released", {24'd0, ram_data}, 32'd0);
        if (host.rsp_valid) begin
            check("rsp_single_pulse", {31'd0, rsp_prev}, 32'd0);
            check("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("rsp_data", {24'd0, host.rsp_rdata}, {24'd0, exp_q.pop_front()});
            rsp_cnt <= rsp_cnt + 1;
        end
        rsp_prev <= host.rsp_valid;
    end

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host.req_valid = 1'b1;
        host.req_wr    = wr;
        host.req_addr  = a;
        host.req_wdata = d;
        if (wr) shadow[a] = d;
        else    exp_q.push_back(shadow[a]);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        drive(wr, a, d);
        for (int n = 0; n < 200; n++) begin
            acc = host.req_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
            stalls++;
        end
        check("send_accepted", {31'd0, acc}, 32'd1);
        host.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            done = !busy && (exp_q.size() == 0);
            if (done) break;
            @(negedge clk);
        end
        check("idle_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int base;
        int nreads;
        logic [AW-1:0] a;
        rst            = 1'b1;
        host.req_valid = 1'b0;
        host.req_wr    = 1'b0;
        host.req_addr  = '0;
        host.req_wdata = '0;
        stalls         = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_rd", {31'd0, ram_rd}, 32'd0);
        check("rst_addr", {24'd0, ram_addr}, 32'd0);
        check("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, host.rsp_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus", {24'd0, ram_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, host.req_ready}, 32'd1);

        // Write 0xA5@0x10, then read it back with exact latency
        send(1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        check("wr_phase_wr", {31'd0, ram_wr}, 32'd1);
        check("wr_phase_addr", {24'd0, ram_addr}, 32'h10);
        check("wr_phase_data", {24'd0, ram_data}, 32'hA5);
        wait_idle();
        drive(1'b0, 8'h10, 8'h00);
        @(posedge clk);
        @(negedge clk);
        host.req_valid = 1'b0;
        check("lat_a_rd", {31'd0, ram_rd}, 32'd0);
        check("lat_a_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_a1_rd", {31'd0, ram_rd}, 32'd1);
        check("lat_a1_addr", {24'd0, ram_addr}, 32'h10);
        check("lat_a1_valid", {31'd0, host.rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_a2_valid", {31'd0, host.rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_a3_valid", {31'd0, host.rsp_valid}, 32'd1);
        check("lat_a3_rdata", {24'd0, host.rsp_rdata}, 32'hA5);
        check("lat_a3_rd", {31'd0, ram_rd}, 32'd0);
        @(negedge clk);
        check("lat_a4_valid", {31'd0, host.rsp_valid}, 32'd0);
        check("lat_a4_hold", {24'd0, host.rsp_rdata}, 32'hA5);

        // Back-to-back writes fill the FIFO after the seventh
        wait_idle();
        stalls = 0;
        for (int i = 0; i < 7; i++) send(1'b1, 8'(8'h20 + i), 8'(i + 1));
        check("fifo_full", {31'd0, host.req_ready}, 32'd0);
        send(1'b1, 8'h27, 8'h08);
        check("stall_cycles", stalls, 32'd1);
        wait_idle();
        base = rsp_cnt;
        for (int i = 0; i < 8; i++) send(1'b0, 8'(8'h20 + i), 8'h00);
        wait_idle();
        check("b2b_rsp_count", rsp_cnt - base, 32'd8);

        // Address extremes
        base = rsp_cnt;
        send(1'b1, 8'hFF, 8'h3C);
        send(1'b1, 8'h00, 8'hC3);
        send(1'b0, 8'hFF, 8'h00);
        send(1'b0, 8'h00, 8'h00);
        wait_idle();
        check("edge_rsp_count", rsp_cnt - base, 32'd2);

        // Reset during RD2 aborts the read
        send(1'b0, 8'h10, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_rd2", {31'd0, ram_rd}, 32'd1);
        base = rsp_cnt;
        rst = 1'b1;
        #1;
        check("abort_cs", {31'd0, ram_cs}, 32'd0);
        check("abort_rd", {31'd0, ram_rd}, 32'd0);
        check("abort_bus", {24'd0, ram_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_rsp", rsp_cnt - base, 32'd0);
        check("abort_ready", {31'd0, host.req_ready}, 32'd1);

        // Random mix against the shadow memory
        base   = rsp_cnt;
        nreads = 0;
        for (int i = 0; i < 200; i++) begin
            if (wq.size() == 0 || $urandom_range(1, 0) == 1) begin
                a = 8'($urandom_range(255, 0));
                wq.push_back(a);
                send(1'b1, a, 8'($urandom_range(255, 0)));
            end else begin
                a = wq[$urandom_range(wq.size() - 1, 0)];
                nreads++;
                send(1'b0, a, 8'h00);
            end
            if ($urandom_range(3, 0) == 0) @(negedge clk);
        end
        wait_idle();
        check("rand_rsp_count", rsp_cnt - base, nreads);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
